// File: rtl/fp_addsub_pipe.sv
// Four-stage pipelined floating-point add/subtract with valid/ready flow control,
// round-to-nearest-even and invalid/overflow/inexact flags. Generic in exponent/fraction width.
module fp_addsub_pipe #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op_sub,
  input  logic [E_WIDTH+M_WIDTH:0]   A,
  input  logic [E_WIDTH+M_WIDTH:0]   B,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [E_WIDTH+M_WIDTH:0]   res,
  output logic                       flag_invalid,
  output logic                       flag_overflow,
  output logic                       flag_inexact
);

  localparam int W   = E_WIDTH + M_WIDTH + 1;
  localparam int SW  = M_WIDTH + 4;            // hidden bit + fraction + guard/round/sticky
  localparam int LZW = $clog2(SW + 1);
  localparam int EW1 = E_WIDTH + 1;
  localparam logic [E_WIDTH-1:0] EMAX = '1;

  logic en;
  logic out_valid_reg;

  assign en       = out_ready | ~out_valid_reg;
  assign in_ready = en;

  // ---------------- stage 1: unpack, classify, order operands ----------------
  logic               sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
  logic [E_WIDTH-1:0] ea, eb;
  logic [M_WIDTH-1:0] fa, fb;
  logic               spec;
  logic [W-1:0]       spec_res;
  logic               spec_inv;

  assign sa     = A[W-1];
  assign ea     = A[W-2:M_WIDTH];
  assign fa     = A[M_WIDTH-1:0];
  assign sb     = B[W-1] ^ op_sub;
  assign eb     = B[W-2:M_WIDTH];
  assign fb     = B[M_WIDTH-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);
  assign a_ge_b = {ea, fa} >= {eb, fb};

  // Specials resolve here and ride the pipe; denormals count as zero.
  always_comb begin
    spec     = 1'b1;
    spec_res = '0;
    spec_inv = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec_res = {1'b0, EMAX, 1'b1, {(M_WIDTH-1){1'b0}}};
      spec_inv = 1'b1;
    end else if (a_inf)             spec_res = {sa, ea, fa};
    else if (b_inf)                 spec_res = {sb, eb, fb};
    else if (a_zero && b_zero)      spec_res = {sa & sb, {(W-1){1'b0}}};
    else if (a_zero)                spec_res = {sb, eb, fb};
    else if (b_zero)                spec_res = {sa, ea, fa};
    else                            spec     = 1'b0;
  end

  logic               s1_valid, s1_spec, s1_inv, s1_sx, s1_sub;
  logic [W-1:0]       s1_sres;
  logic [E_WIDTH-1:0] s1_ex, s1_diff;
  logic [M_WIDTH:0]   s1_mx, s1_my;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0; s1_spec <= 1'b0; s1_inv <= 1'b0; s1_sres <= '0;
      s1_sx <= 1'b0; s1_sub <= 1'b0; s1_ex <= '0; s1_diff <= '0; s1_mx <= '0; s1_my <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_spec  <= spec;
      s1_inv   <= spec_inv;
      s1_sres  <= spec_res;
      s1_sx    <= a_ge_b ? sa : sb;
      s1_sub   <= sa ^ sb;
      s1_ex    <= a_ge_b ? ea : eb;
      s1_diff  <= a_ge_b ? (ea - eb) : (eb - ea);
      s1_mx    <= a_ge_b ? {1'b1, fa} : {1'b1, fb};
      s1_my    <= a_ge_b ? {1'b1, fb} : {1'b1, fa};
    end
  end

  // ---------------- stage 2: align smaller operand ----------------
  logic [2*SW-1:0] wide;
  logic [SW-1:0]   y_al;

  always_comb begin
    wide = {s1_my, 3'b000, {SW{1'b0}}} >> s1_diff;
    if (32'(s1_diff) >= SW - 1) y_al = {{(SW-1){1'b0}}, 1'b1};
    else                        y_al = {wide[2*SW-1:SW+1], wide[SW] | (|wide[SW-1:0])};
  end

  logic               s2_valid, s2_spec, s2_inv, s2_sx, s2_sub;
  logic [W-1:0]       s2_sres;
  logic [E_WIDTH-1:0] s2_ex;
  logic [SW-1:0]      s2_mx, s2_my;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid <= 1'b0; s2_spec <= 1'b0; s2_inv <= 1'b0; s2_sres <= '0;
      s2_sx <= 1'b0; s2_sub <= 1'b0; s2_ex <= '0; s2_mx <= '0; s2_my <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_spec  <= s1_spec;
      s2_inv   <= s1_inv;
      s2_sres  <= s1_sres;
      s2_sx    <= s1_sx;
      s2_sub   <= s1_sub;
      s2_ex    <= s1_ex;
      s2_mx    <= {s1_mx, 3'b000};
      s2_my    <= y_al;
    end
  end

  // ---------------- stage 3: add/subtract and normalize ----------------
  logic [SW:0]    sum;
  logic [LZW-1:0] lz;
  logic [SW-1:0]  n_mant;
  logic [EW1-1:0] n_exp;
  logic           n_sign, n_zero, n_zinex;

  assign sum = s2_sub ? ({1'b0, s2_mx} - {1'b0, s2_my}) : ({1'b0, s2_mx} + {1'b0, s2_my});

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (sum[i]) lz = LZW'(SW - 1 - i);
  end

  always_comb begin
    n_mant  = sum[SW-1:0];
    n_exp   = {1'b0, s2_ex};
    n_sign  = s2_sx;
    n_zero  = 1'b0;
    n_zinex = 1'b0;
    if (sum[SW]) begin
      n_mant = {sum[SW:2], sum[1] | sum[0]};
      n_exp  = {1'b0, s2_ex} + EW1'(1);
    end else if (sum == '0) begin
      n_zero = 1'b1;
      n_sign = 1'b0;
    end else if (32'(s2_ex) <= 32'(lz)) begin
      // Result would be subnormal: flush to signed zero.
      n_zero  = 1'b1;
      n_zinex = 1'b1;
    end else begin
      n_mant = sum[SW-1:0] << lz;
      n_exp  = {1'b0, s2_ex} - EW1'(lz);
    end
  end

  logic           s3_valid, s3_spec, s3_inv, s3_sign, s3_zero, s3_zinex;
  logic [W-1:0]   s3_sres;
  logic [EW1-1:0] s3_exp;
  logic [SW-1:0]  s3_mant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s3_valid <= 1'b0; s3_spec <= 1'b0; s3_inv <= 1'b0; s3_sres <= '0; s3_sign <= 1'b0;
      s3_zero <= 1'b0; s3_zinex <= 1'b0; s3_exp <= '0; s3_mant <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_spec  <= s2_spec;
      s3_inv   <= s2_inv;
      s3_sres  <= s2_sres;
      s3_sign  <= n_sign;
      s3_zero  <= n_zero;
      s3_zinex <= n_zinex;
      s3_exp   <= n_exp;
      s3_mant  <= n_mant;
    end
  end

  // ---------------- stage 4: round to nearest even and pack ----------------
  logic                 g_bit, r_bit, s_bit, inc;
  logic [M_WIDTH+1:0]   rnd;
  logic [EW1-1:0]       r_exp;
  logic [M_WIDTH-1:0]   r_frac;
  logic [W-1:0]         p_res;
  logic                 p_inv, p_ovf, p_inx;

  assign g_bit  = s3_mant[2];
  assign r_bit  = s3_mant[1];
  assign s_bit  = s3_mant[0];
  assign inc    = g_bit & (r_bit | s_bit | s3_mant[3]);
  assign rnd    = {1'b0, s3_mant[SW-1:3]} + {{(M_WIDTH+1){1'b0}}, inc};
  assign r_exp  = s3_exp + {{E_WIDTH{1'b0}}, rnd[M_WIDTH+1]};
  assign r_frac = rnd[M_WIDTH+1] ? rnd[M_WIDTH:1] : rnd[M_WIDTH-1:0];

  always_comb begin
    p_res = {s3_sign, r_exp[E_WIDTH-1:0], r_frac};
    p_inv = 1'b0;
    p_ovf = 1'b0;
    p_inx = g_bit | r_bit | s_bit;
    if (s3_spec) begin
      p_res = s3_sres;
      p_inv = s3_inv;
      p_inx = 1'b0;
    end else if (s3_zero) begin
      p_res = {s3_sign, {(W-1){1'b0}}};
      p_inx = s3_zinex;
    end else if (r_exp >= {1'b0, EMAX}) begin
      p_res = {s3_sign, EMAX, {M_WIDTH{1'b0}}};
      p_ovf = 1'b1;
      p_inx = 1'b1;
    end
  end

  logic [W-1:0] res_reg;
  logic         inv_reg, ovf_reg, inx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0; res_reg <= '0; inv_reg <= 1'b0; ovf_reg <= 1'b0; inx_reg <= 1'b0;
    end else if (en) begin
      out_valid_reg <= s3_valid;
      res_reg       <= p_res;
      inv_reg       <= p_inv;
      ovf_reg       <= p_ovf;
      inx_reg       <= p_inx;
    end
  end

  assign out_valid     = out_valid_reg;
  assign res           = res_reg;
  assign flag_invalid  = inv_reg;
  assign flag_overflow = ovf_reg;
  assign flag_inexact  = inx_reg;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single and half precision vectors, stall streaming
// and mid-flight reset, all checked against hand-computed results.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] a, b, res;
  logic        fi, fo, fx;
  logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_res;
  logic        h_fi, h_fo, h_fx;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.E_WIDTH(8), .M_WIDTH(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .res(res),
    .flag_invalid(fi), .flag_overflow(fo), .flag_inexact(fx)
  );

  fp_addsub_pipe #(.E_WIDTH(5), .M_WIDTH(10)) dut_h (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .op_sub(h_op_sub),
    .A(h_a), .B(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready), .res(h_res),
    .flag_invalid(h_fi), .flag_overflow(h_fo), .flag_inexact(h_fx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One isolated operation; flags packed as {invalid, overflow, inexact}.
  task automatic run_op(input string tag, input bit half, input logic [31:0] av,
                        input logic [31:0] bv, input logic sub,
                        input logic [31:0] er, input logic [2:0] ef);
    int lat;
    logic [31:0] got;
    logic [2:0]  gf;
    @(negedge clk);
    if (half) begin h_a = av[15:0]; h_b = bv[15:0]; h_op_sub = sub; h_in_valid = 1'b1; end
    else      begin a = av;         b = bv;         op_sub = sub;   in_valid = 1'b1;   end
    @(posedge clk); #1;
    in_valid = 1'b0; h_in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (half ? h_out_valid : out_valid) begin lat = n; break; end
    end
    got = half ? {16'h0, h_res} : res;
    gf  = half ? {h_fi, h_fo, h_fx} : {fi, fo, fx};
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_res"}, 64'(got), 64'(er));
    check({tag, "_flags"}, 64'(gf), 64'(ef));
    $display("op %s a=%h b=%h sub=%0d -> res=%h flags=%b lat=%0d", tag, av, bv, sub, got, gf, lat);
  endtask

  logic [31:0] fv [0:9];
  logic [31:0] exp_q [$];

  initial begin
    int sent, recv;
    logic stale;
    fv[0] = 32'h00000000; fv[1] = 32'h3F800000; fv[2] = 32'h40000000; fv[3] = 32'h40400000;
    fv[4] = 32'h40800000; fv[5] = 32'h40A00000; fv[6] = 32'h40C00000; fv[7] = 32'h40E00000;
    fv[8] = 32'h41000000; fv[9] = 32'h41100000;

    rst = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_op_sub = 1'b0; h_a = '0; h_b = '0; h_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_res", 64'(res), 64'd0);
    check("rst_flags", 64'({fi, fo, fx}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_h_out_valid", 64'(h_out_valid), 64'd0);

    run_op("add_1_2",     0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000);
    run_op("sub_equal",   0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 3'b000);
    run_op("negzero",     0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 3'b000);
    run_op("tie_even",    0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'b001);
    run_op("round_up",    0, 32'h3F800000, 32'h34400000, 0, 32'h3F800002, 3'b001);
    run_op("inf_m_inf",   0, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 3'b100);
    run_op("overflow",    0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b011);
    run_op("cancel_3m2",  0, 32'h40400000, 32'h40000000, 1, 32'h3F800000, 3'b000);
    run_op("neg_result",  0, 32'h3F800000, 32'h40000000, 1, 32'hBF800000, 3'b000);
    run_op("nan_in",      0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 3'b100);
    run_op("inf_fin",     0, 32'h7F800000, 32'h3F800000, 0, 32'h7F800000, 3'b000);
    run_op("zero_m_x",    0, 32'h00000000, 32'h3F800000, 1, 32'hBF800000, 3'b000);
    run_op("denorm_flush",0, 32'h00000001, 32'h00000000, 0, 32'h00000000, 3'b000);
    run_op("underflow",   0, 32'h00800000, 32'h00C00000, 1, 32'h80000000, 3'b001);
    run_op("h_add_1_1",   1, 32'h3C00,     32'h3C00,     0, 32'h4000,     3'b000);
    run_op("h_overflow",  1, 32'h7BFF,     32'h7BFF,     0, 32'h7C00,     3'b011);

    // Back-to-back stream of k+1.0 with the consumer stalled in cycles 5-7.
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (sent < 8);
      a = fv[sent + 1]; b = fv[1]; op_sub = 1'b0;
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) check("stream_spurious", 64'(out_valid), 64'd0);
        else check("stream_res", 64'(res), 64'(exp_q[0]));
        if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_ready) begin
          $display("stream recv %0d res=%h", recv, res);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          recv++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(fv[sent + 2]);
        sent++;
      end
    end
    check("stream_count", 64'(recv), 64'd8);

    // Reset with the pipe full: nothing may survive it.
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = fv[i + 1]; b = fv[1]; op_sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_res", 64'(res), 64'd0);
    check("reset_flags", 64'({fi, fo, fx}), 64'd0);
    $display("reset asserted with operations in flight");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
